// File: rtl/csa_resolver_if.sv
// csa_resolver_if: operand and result handshakes of the carry-save resolver.
// master drives operands and out_ready; slave is the resolver.
interface csa_resolver_if #(
  parameter int W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_vec;
  logic [W-1:0] carry_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  modport master (
    output in_valid,
    output sum_vec,
    output carry_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result
  );

  modport slave (
    input  in_valid,
    input  sum_vec,
    input  carry_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result
  );
endinterface

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a sum/carry pair to binary, CHUNK bits per clock.
// Optional ovf output when CSA_RESOLVER_OVF_EN is defined.
module csa_resolver #(
  parameter int W     = 24,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          reset,
  csa_resolver_if.slave io,
  output logic          busy
`ifdef CSA_RESOLVER_OVF_EN
  ,
  output logic          ovf
`endif
);
  localparam int N  = W / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if ((W % CHUNK) != 0 || W < CHUNK) begin : g_bad_cfg
    $error("csa_resolver: W must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   sum_q;
  logic [W:0]     csh_q;
  logic [W-1:0]   res_q;
  logic [KW-1:0]  k_q;
  logic           c_q;
  logic [CHUNK:0] ch;
  logic           last;
  logic           acc;

  assign ch   = {1'b0, sum_q[CHUNK-1:0]}
              + {1'b0, csh_q[CHUNK-1:0]}
              + (CHUNK+1)'(c_q);
  assign last = (k_q == KW'(N - 1));
  assign acc  = (state_q == IDLE) && io.in_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.in_valid) state_d = ADD;
      ADD:     if (last) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operands shift down one chunk per cycle; result fills from the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      csh_q <= '0;
      res_q <= '0;
      k_q   <= '0;
      c_q   <= 1'b0;
    end else if (acc) begin
      sum_q <= io.sum_vec;
      csh_q <= {io.carry_vec, 1'b0};
      k_q   <= '0;
      c_q   <= 1'b0;
    end else if (state_q == ADD) begin
      sum_q <= sum_q >> CHUNK;
      csh_q <= csh_q >> CHUNK;
      res_q <= W'({ch[CHUNK-1:0], res_q} >> CHUNK);
      k_q   <= k_q + 1'b1;
      c_q   <= ch[CHUNK];
    end
  end

`ifdef CSA_RESOLVER_OVF_EN
  logic ovf_q;

  // On the last chunk the original csh bit W has shifted down to CHUNK.
  always_ff @(posedge clk) begin
    if (reset)                      ovf_q <= 1'b0;
    else if (acc)                   ovf_q <= 1'b0;
    else if (state_q == ADD && last) ovf_q <= ch[CHUNK] | csh_q[CHUNK];
  end

  assign ovf = ovf_q;
`endif

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign busy         = (state_q == ADD);
  assign io.result    = res_q;
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed vectors for csa_resolver (W=24, CHUNK=4).
// Linear step sequence with immediate assertions at each check.
module tb_csa_resolver;
  logic clk;
  logic reset;
  logic busy;
`ifdef CSA_RESOLVER_OVF_EN
  logic ovf;
`endif
  int vecs;
  int bad;

  csa_resolver_if #(.W(24)) bus ();

  csa_resolver #(
    .W(24),
    .CHUNK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus.slave),
    .busy(busy)
`ifdef CSA_RESOLVER_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [23:0] s, input logic [23:0] c);
    bus.in_valid  = 1'b1;
    bus.sum_vec   = s;
    bus.carry_vec = c;
    tick();
    bus.in_valid = 1'b0;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 1;
    while (!bus.out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd7);
  endtask

  task automatic finish_op(input string tag, input logic [23:0] exp_res,
                           input logic exp_ovf);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
`ifdef CSA_RESOLVER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x");
`endif
    chk({tag, "_no_inready"}, 32'(bus.in_ready), 32'd0);
    tick();
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vecs          = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sum_vec   = 24'hAAAAAA;
    bus.carry_vec = 24'h555555;
    bus.out_ready = 1'b0;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid2", 32'(bus.out_valid), 32'd0);
    chk("rst_busy2", 32'(busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'h000000);
`ifdef CSA_RESOLVER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    bus.out_ready = 1'b1;
    do_accept(24'h000005, 24'h000003);
    wait_done("basic");
    finish_op("basic", 24'h00000B, 1'b0);

    do_accept(24'h0FFFFF, 24'h000001);
    wait_done("ripple");
    finish_op("ripple", 24'h100001, 1'b0);

    do_accept(24'hFFFFFF, 24'h800000);
    wait_done("ovf_top");
    finish_op("ovf_top", 24'hFFFFFF, 1'b1);

    do_accept(24'hFFFFFF, 24'h000001);
    wait_done("ovf_carry");
    finish_op("ovf_carry", 24'h000001, 1'b1);

    do_accept(24'hFFFFFF, 24'hFFFFFF);
    wait_done("max");
    finish_op("max", 24'hFFFFFD, 1'b1);

    bus.out_ready = 1'b0;
    do_accept(24'h123456, 24'h000100);
    wait_done("bp_a");
    bus.in_valid  = 1'b1;
    bus.sum_vec   = 24'h000777;
    bus.carry_vec = 24'h000111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_result", 32'(bus.result), 32'h123656);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
`ifdef CSA_RESOLVER_OVF_EN
    chk("bp_hold_ovf", 32'(ovf), 32'd0);
`endif
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    do_accept(24'h000777, 24'h000111);
    wait_done("bp_b");
    finish_op("bp_b", 24'h000999, 1'b0);

    do_accept(24'hABCDEF, 24'h111111);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'h000000);
    do_accept(24'h000010, 24'h000008);
    wait_done("post_rst");
    finish_op("post_rst", 24'h000020, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/csa_resolver.md
# csa_resolver

Multi-cycle carry-save resolver for the Wallace-tree multiplier datapath. It takes the redundant sum/carry vector pair produced by the final 5:2 / 3:2 compressor stage and converts it to a single binary word using a chunked ripple adder, CHUNK bits per clock. A valid/ready handshake sits on both sides, so it can be placed between the compressor tree and any downstream register or bus. It is the consumer of the compressor outputs: the compressors write carry-save form, and this block reads it back as binary.

## Interface
- W, 24, width of sum_vec, carry_vec and result; must be a multiple of CHUNK
- CHUNK, 4, bits resolved per clock; N = W/CHUNK add cycles
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  sum_vec/carry_vec valid
- in_ready  output  1  block can accept; high only in IDLE
- sum_vec  input  W  sum bits, bit i weight 2^i
- carry_vec  input  W  carry bits, bit i weight 2^(i+1)
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  downstream accepts result
- result  output  W  (sum_vec + 2*carry_vec) mod 2^W
- busy  output  1  high in ADD
- ovf  output  1  present only with CSA_RESOLVER_OVF_EN (see Configuration)

## Operation
- Accepts one operand pair and adds it using a chunked ripple adder; only one operation is in flight at a time. The FSM has states IDLE, ADD and DONE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge:
  - latch sum_reg=sum_vec and csh_reg={carry_vec,1'b0} (W+1 bits);
  - clear chunk index k=0 and the carry register c=0;
  - go to ADD.
- ADD: at each edge, chunk k is computed as {c', r[k*CHUNK +: CHUNK]} = sum_reg chunk + csh_reg chunk + c.
  - c is updated to c' and k is incremented.
  - After chunk N-1 the FSM goes to DONE.
  - in_valid is ignored while in ADD.
- DONE: out_valid=1 and result is held stable. When out_valid && out_ready at an edge, the FSM goes to IDLE.
- result is not updated in any state other than ADD.
- Overflow term: the final c OR csh_reg[W] (both have weight 2^W). It is dropped from result.
- Arithmetic is unsigned. The maximum true sum is 3*2^W-3, which fits in W+2 bits.

## Timing
- Reset values: in_ready=1 in the cycle after the reset edge, out_valid=0, busy=0, result=0, ovf=0. State=IDLE, k=0, c=0.
- Latency: with the accept at edge E0, chunks are computed at E1..EN. out_valid is high in the cycle after EN, i.e. N+1 edges after the accept. With the defaults this is 7 edges.
- Throughput: at most one result per N+2 cycles.
  - There is no same-cycle turnaround: in_ready rises in the cycle after the output handshake.
  - in_ready and out_valid are never high at the same time.
- Backpressure: DONE holds indefinitely while out_ready=0, and result and ovf do not change.
- out_ready while not in DONE: no effect.
- in_valid && out_ready in the same cycle during DONE: only the output handshake completes. The input is accepted no earlier than the next IDLE cycle.
- Reset mid-operation (ADD or DONE): the FSM aborts to IDLE at that edge and all outputs take their reset values. No partial result is ever presented.
- in_ready, out_valid and busy are decoded from the state register only; they have no combinational path from any input.

## Configuration
- CSA_RESOLVER_OVF_EN defined:
  - the ovf output port exists;
  - ovf is registered and updated at edge EN to (final c | csh_reg[W]);
  - ovf is valid with out_valid and held in DONE;
  - ovf is cleared by reset and at the accept edge.
- Not defined:
  - the ovf port and its register are absent;
  - result is silently truncated mod 2^W;
  - all other behaviour is identical.

## Test plan
All scenarios use W=24, CHUNK=4.
- Reset: hold reset high 2 cycles with in_valid=1 -> after release in_ready=1, out_valid=0, busy=0, result=0x000000; nothing is accepted during reset.
- Basic add: sum=0x000005, carry=0x000003, out_ready=1 -> out_valid high exactly 7 edges after accept, result=0x00000B, ovf=0; in_ready=1 one cycle after the output handshake.
- Cross-chunk ripple: sum=0x0FFFFF, carry=0x000001 -> result=0x100001, ovf=0.
- Overflow: sum=0xFFFFFF, carry=0x800000 -> result=0xFFFFFF; with the macro ovf=1; without it the port is absent and result is unchanged.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new data -> result stable, in_ready=0, new data not accepted; out_ready=1 -> return to IDLE, then the second pair is accepted and resolved correctly.
- Mid-op reset: reset asserted at edge E3 of an ADD -> next cycle state IDLE, out_valid=0, busy=0, result=0; a following operation sum=0x000010, carry=0x000008 gives result=0x000020.
